addsub_accumulator: RTL and testbench
=====================================

# addsub_accumulator

Parametrised, sequential successor to the 4-bit combinational add/subtract stage. It holds a WIDTH-bit two's-complement accumulator and accepts one LOAD/ADD/SUB/CLEAR command per start pulse. It produces carry, overflow and sticky-overflow flags, with optional saturation. It then converts the signed result to sign plus packed-BCD magnitude over WIDTH cycles, ready for the seven-segment decoders downstream.

## Interface
- WIDTH, 8, accumulator/operand width in bits; legal range 4..32
- SATURATE, 0, 1 = clamp to most-positive/most-negative value on signed overflow; 0 = wrap
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  command strobe; sampled only while busy=0
- op  input  2  command: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- operand  input  WIDTH  two's-complement operand B
- busy  output  1  high from the cycle after start is accepted up to and including the done cycle
- done  output  1  one-cycle pulse; acc, flags and BCD outputs are final
- acc  output  WIDTH  accumulator value
- carry  output  1  carry-out of last ADD/SUB
- ovf  output  1  signed overflow of last ADD/SUB
- ovf_sticky  output  1  OR of every ovf since last CLEAR/reset
- neg  output  1  sign of acc, valid with bcd
- bcd  output  4*DIGITS  packed BCD magnitude of acc, digit 0 in bits [3:0]; DIGITS = ((WIDTH-1)*77)/256 + 1

## Operation
- FSM states: IDLE, EXEC, CONV, DONE.
  - IDLE → EXEC on start.
  - EXEC → CONV always.
  - CONV runs WIDTH iterations → DONE.
  - DONE → IDLE always.
- start is ignored in every state except IDLE. op and operand are captured on the accepting edge.
- EXEC applies the op and registers the result:
  - LOAD: acc=operand; carry=0; ovf=0.
  - ADD: {carry, sum} = acc + operand.
  - SUB: {carry, sum} = acc + ~operand + 1, so carry=1 means no borrow.
  - ovf for ADD/SUB = operands' sign bits as applied to the adder are equal and the sum's sign bit differs from them.
  - CLEAR: acc=0; carry=0; ovf=0; ovf_sticky=0.
- SATURATE=1 and ovf=1: acc = 0x7F..F when the true result is positive, 0x80..0 when negative. Flags are unchanged by clamping.
- ovf_sticky is set in EXEC whenever ovf=1.
- CONV computes magnitude = neg ? -acc : acc as WIDTH-bit unsigned. The most-negative value yields 2^(WIDTH-1).
  - Conversion is iterative double-dabble: per cycle, add 3 to each digit ≥5, then shift in one magnitude bit (MSB first).
- neg and bcd hold their previous values until the DONE cycle, then update together. acc and flags update at the end of EXEC.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE; every output is 0, including bcd, neg, ovf_sticky, busy and done.
- Reset mid-operation: abort, all outputs 0, no done pulse. The first start after release is accepted normally.
- Latency: start sampled at edge 0; busy=1 from edge 1; done=1 for exactly the cycle after edge WIDTH+2.
  - Throughput is one command per WIDTH+3 cycles.
- start held high: re-accepted on the first IDLE cycle after DONE.
- start high during DONE is ignored.
- Sequential arithmetic width: the full WIDTH+1-bit sum is computed; no other width extension.

## Structure
- Package addsub_pkg:
  - op_t enum (OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR);
  - state_t enum;
  - function bcd_digits(width) returning the DIGITS formula.
- Sub-module bin2bcd_seq:
  - parameters WIDTH, DIGITS;
  - ports clk, rst_n, start, bin, busy, done, bcd;
  - iterative double-dabble, WIDTH cycles.
  - The top FSM starts it in EXEC→CONV and waits on its done.
- Top level: FSM, accumulator datapath, flag logic, saturation mux.

## Test plan
- WIDTH=8. Reset, then LOAD 100 → acc=0x64, neg=0, bcd=0x100, carry=0, ovf=0; done exactly 10 cycles after the start edge.
- Then ADD 27 → acc=0x7F, bcd=0x127, ovf=0. Then ADD 1:
  - SATURATE=0 → acc=0x80, ovf=1, ovf_sticky=1, neg=1, bcd=0x128.
  - SATURATE=1 → acc=0x7F, ovf=1, bcd=0x127.
- LOAD 5, SUB 9 → acc=0xFC, carry=0, ovf=0, neg=1, bcd=0x004. LOAD 9, SUB 5 → acc=0x04, carry=1, neg=0.
- Start pulses every cycle during busy → exactly one command executed, single one-cycle done; bcd/neg unchanged until done.
- rst_n low for 1 cycle during CONV → all outputs 0, no done; next LOAD 3 → bcd=0x003, done on schedule.
- Overflow then CLEAR → acc=0, ovf_sticky=0. WIDTH=4, LOAD 8 (-8) → neg=1, bcd=0x8.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and sizing helper for the sequential add/subtract accumulator.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CONV,
    DONE
  } state_t;

  // Decimal digits needed for a magnitude of up to 2^(width-1); 77/256 ~ log10(2).
  function automatic int unsigned bcd_digits(input int unsigned width);
    return ((width - 1) * 77) / 256 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary to packed-BCD converter, one input bit per cycle.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [5:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    adj    = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (busy_q) begin
      bcd_d = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = 6'(WIDTH);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/addsub_accumulator.sv
// Two's-complement accumulator with LOAD/ADD/SUB/CLEAR, overflow flags, optional
// saturation, and sign + BCD magnitude output produced by a sequential converter.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic        SATURATE = 1'b0,
  localparam int unsigned DIGITS  = bcd_digits(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    operand,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    acc,
  output logic                carry,
  output logic                ovf,
  output logic                ovf_sticky,
  output logic                neg,
  output logic [4*DIGITS-1:0] bcd
);

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [WIDTH-1:0]    operand_q, operand_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                sticky_q, sticky_d;
  logic                neg_q, neg_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [WIDTH-1:0]    b_eff;
  logic                cin;
  logic [WIDTH:0]      sum;
  logic                add_ovf;
  logic                conv_start, conv_busy, conv_done;
  logic [WIDTH-1:0]    conv_bin;
  logic [4*DIGITS-1:0] conv_bcd;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    sticky_d   = sticky_q;
    neg_d      = neg_q;
    bcd_d      = bcd_q;
    conv_start = 1'b0;

    b_eff   = (op_q == OP_SUB) ? ~operand_q : operand_q;
    cin     = (op_q == OP_SUB);
    sum     = {1'b0, acc_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    add_ovf = (acc_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = EXEC;
          op_d      = op_t'(op);
          operand_d = operand;
        end
      end
      EXEC: begin
        state_d    = CONV;
        conv_start = 1'b1;
        case (op_q)
          OP_LOAD: begin
            acc_d   = operand_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = add_ovf;
            if (add_ovf) begin
              sticky_d = 1'b1;
              // On overflow the true result carries the sign shared by both addends.
              if (SATURATE)
                acc_d = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
          end
          default: begin
            acc_d    = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
          end
        endcase
      end
      CONV: begin
        if (conv_done && !conv_busy) begin
          state_d = DONE;
          neg_d   = acc_q[WIDTH-1];
          bcd_d   = conv_bcd;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Converter is loaded from the value being registered into acc this cycle.
    conv_bin = acc_d[WIDTH-1] ? ('0 - acc_d) : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_LOAD;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      sticky_q  <= sticky_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
    end
  end

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS)
  ) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(conv_start),
    .bin  (conv_bin),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign acc        = acc_q;
  assign carry      = carry_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;
  assign neg        = neg_q;
  assign bcd        = bcd_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench: wrap and saturating WIDTH=8 instances side by side, plus a WIDTH=4 instance.
module tb_addsub_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] operand = 8'd0;
  logic       start_c = 1'b0;
  logic [1:0] op_c = 2'd0;
  logic [3:0] operand_c = 4'd0;

  logic       busy_a, done_a, carry_a, ovf_a, st_a, neg_a;
  logic [7:0] acc_a;
  logic [11:0] bcd_a;
  logic       busy_b, done_b, carry_b, ovf_b, st_b, neg_b;
  logic [7:0] acc_b;
  logic [11:0] bcd_b;
  logic       busy_c, done_c, carry_c, ovf_c, st_c, neg_c;
  logic [3:0] acc_c;
  logic [3:0] bcd_c;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  addsub_accumulator #(.WIDTH(8), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
    .busy(busy_a), .done(done_a), .acc(acc_a), .carry(carry_a), .ovf(ovf_a),
    .ovf_sticky(st_a), .neg(neg_a), .bcd(bcd_a));

  addsub_accumulator #(.WIDTH(8), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
    .busy(busy_b), .done(done_b), .acc(acc_b), .carry(carry_b), .ovf(ovf_b),
    .ovf_sticky(st_b), .neg(neg_b), .bcd(bcd_b));

  addsub_accumulator #(.WIDTH(4), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .op(op_c), .operand(operand_c),
    .busy(busy_c), .done(done_c), .acc(acc_c), .carry(carry_c), .ovf(ovf_c),
    .ovf_sticky(st_c), .neg(neg_c), .bcd(bcd_c));

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  opnd;
    logic [7:0]  acc;
    logic        c;
    logic        v;
    logic        st;
    logic        n;
    logic [11:0] bcd;
    logic [7:0]  sacc;
    logic        sn;
    logic [11:0] sbcd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Issue one command to the WIDTH=8 pair; returns edges from accept to done.
  task automatic run_cmd(input logic [1:0] o, input logic [7:0] v, output int lat, output logic stable);
    logic [11:0] bp;
    logic        np;
    @(negedge clk);
    bp = bcd_a; np = neg_a;
    start = 1'b1; op = o; operand = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    stable = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done_a) break;
      if (bcd_a !== bp || neg_a !== np) stable = 1'b0;
    end
  endtask

  initial begin
    int   lat;
    logic stable;
    int   ndone;
    int   first_lat;

    vecs[0]  = '{2'd0, 8'd100,  8'h64, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 8'h64, 1'b0, 12'h100};
    vecs[1]  = '{2'd1, 8'd27,   8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 12'h127, 8'h7F, 1'b0, 12'h127};
    vecs[2]  = '{2'd1, 8'd1,    8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 12'h128, 8'h7F, 1'b0, 12'h127};
    vecs[3]  = '{2'd3, 8'd0,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000};
    vecs[4]  = '{2'd0, 8'd5,    8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 12'h005, 8'h05, 1'b0, 12'h005};
    vecs[5]  = '{2'd2, 8'd9,    8'hFC, 1'b0, 1'b0, 1'b0, 1'b1, 12'h004, 8'hFC, 1'b1, 12'h004};
    vecs[6]  = '{2'd0, 8'd9,    8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 12'h009, 8'h09, 1'b0, 12'h009};
    vecs[7]  = '{2'd2, 8'd5,    8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 12'h004, 8'h04, 1'b0, 12'h004};
    vecs[8]  = '{2'd0, 8'h80,   8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 12'h128, 8'h80, 1'b1, 12'h128};
    vecs[9]  = '{2'd2, 8'd1,    8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 12'h127, 8'h80, 1'b1, 12'h128};
    vecs[10] = '{2'd3, 8'd0,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000};

    #1;
    check("rst_acc",  {24'd0, acc_a}, 32'h0);
    check("rst_bcd",  {20'd0, bcd_a}, 32'h0);
    check("rst_flags", {26'd0, busy_a, done_a, carry_a, ovf_a, st_a, neg_a}, 32'h0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].op, vecs[i].opnd, lat, stable);
      check($sformatf("v%0d_latency", i), lat, 32'd10);
      check($sformatf("v%0d_done_b", i), {31'd0, done_b}, 32'd1);
      check($sformatf("v%0d_busy", i), {31'd0, busy_a}, 32'd1);
      check($sformatf("v%0d_hold", i), {31'd0, stable}, 32'd1);
      check($sformatf("v%0d_acc", i), {24'd0, acc_a}, {24'd0, vecs[i].acc});
      check($sformatf("v%0d_carry", i), {31'd0, carry_a}, {31'd0, vecs[i].c});
      check($sformatf("v%0d_ovf", i), {31'd0, ovf_a}, {31'd0, vecs[i].v});
      check($sformatf("v%0d_sticky", i), {31'd0, st_a}, {31'd0, vecs[i].st});
      check($sformatf("v%0d_neg", i), {31'd0, neg_a}, {31'd0, vecs[i].n});
      check($sformatf("v%0d_bcd", i), {20'd0, bcd_a}, {20'd0, vecs[i].bcd});
      check($sformatf("v%0d_sat_acc", i), {24'd0, acc_b}, {24'd0, vecs[i].sacc});
      check($sformatf("v%0d_sat_flags", i), {29'd0, carry_b, ovf_b, st_b},
            {29'd0, vecs[i].c, vecs[i].v, vecs[i].st});
      check($sformatf("v%0d_sat_neg", i), {31'd0, neg_b}, {31'd0, vecs[i].sn});
      check($sformatf("v%0d_sat_bcd", i), {20'd0, bcd_b}, {20'd0, vecs[i].sbcd});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {30'd0, done_a, busy_a}, 32'd0);
    end

    // start held high across a whole command, through DONE, with a changing operand
    @(negedge clk);
    start = 1'b1; op = 2'd1; operand = 8'd5;
    @(posedge clk); #1;
    operand = 8'd100;
    ndone = 0; first_lat = -1; stable = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 11) start = 1'b0;
      if (done_a) begin
        ndone++;
        if (first_lat < 0) first_lat = k;
      end else if (ndone == 0 && bcd_a !== 12'h000) stable = 1'b0;
    end
    check("hold_done_count", ndone, 32'd1);
    check("hold_latency", first_lat, 32'd10);
    check("hold_acc", {24'd0, acc_a}, 32'h05);
    check("hold_bcd", {20'd0, bcd_a}, 32'h005);
    check("hold_bcd_stable", {31'd0, stable}, 32'd1);
    check("hold_idle", {31'd0, busy_a}, 32'd0);

    // reset pulse in the middle of conversion
    @(negedge clk);
    start = 1'b1; op = 2'd0; operand = 8'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("abort_acc", {24'd0, acc_a}, 32'h0);
    check("abort_bcd", {20'd0, bcd_a}, 32'h0);
    check("abort_flags", {26'd0, busy_a, done_a, carry_a, ovf_a, st_a, neg_a}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);
    check("abort_still_zero", {23'd0, busy_a, acc_a}, 32'h0);
    run_cmd(2'd0, 8'd3, lat, stable);
    check("post_rst_latency", lat, 32'd10);
    check("post_rst_acc", {24'd0, acc_a}, 32'h03);
    check("post_rst_bcd", {20'd0, bcd_a}, 32'h003);

    // WIDTH=4 most-negative value
    @(negedge clk);
    start_c = 1'b1; op_c = 2'd0; operand_c = 4'h8;
    @(posedge clk); #1;
    start_c = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done_c) break;
    end
    check("w4_latency", lat, 32'd6);
    check("w4_acc", {28'd0, acc_c}, 32'h8);
    check("w4_neg", {31'd0, neg_c}, 32'd1);
    check("w4_bcd", {28'd0, bcd_c}, 32'h8);
    check("w4_flags", {29'd0, carry_c, ovf_c, st_c}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
